// File: rtl/i281_run_controller.sv
// Run/stop/step/breakpoint sequencer that gates the i281 datapath through `run`.
// Optional retired-instruction counter enabled with I281_INSTR_COUNT_EN.
module i281_run_controller #(
   parameter int PC_W  = 6,
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start_btn,
   input  logic             stop_btn,
   input  logic             step_btn,
   input  logic             bp_enable,
   input  logic [PC_W-1:0]  bp_addr,
   input  logic [PC_W-1:0]  current_pc,
   input  logic             multicycle_flag,
   input  logic             next_instr_trigger,
   output logic             run,
   output logic             halted,
   output logic             at_break,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STEP  = 2'd2,
      ST_BREAK = 2'd3
   } run_state_t;

   run_state_t state_r, state_nxt_s;
   logic start_q_r, stop_q_r, step_q_r;
   logic instr_start_r, skip_bp_r, pend_stop_r, ret_brk_r;
   logic skip_bp_nxt_s, pend_stop_nxt_s, ret_brk_nxt_s;
   logic start_p_s, stop_p_s, step_p_s;
   logic bp_hit_s, run_s, done_s, stop_req_s;

   assign start_p_s  = start_btn & ~start_q_r;
   assign stop_p_s   = stop_btn  & ~stop_q_r;
   assign step_p_s   = step_btn  & ~step_q_r;

   assign bp_hit_s   = bp_enable & instr_start_r & ~skip_bp_r & (current_pc == bp_addr);
   assign run_s      = ((state_r == ST_RUN) & ~bp_hit_s) | (state_r == ST_STEP);
   assign done_s     = run_s & (~multicycle_flag | next_instr_trigger);
   assign stop_req_s = stop_p_s | pend_stop_r;

   // Next-state logic; a stop in RUN is only honoured on an instruction boundary.
   always_comb begin
      state_nxt_s     = state_r;
      skip_bp_nxt_s   = skip_bp_r & ~done_s;
      pend_stop_nxt_s = pend_stop_r;
      ret_brk_nxt_s   = ret_brk_r;
      case (state_r)
         ST_IDLE: begin
            pend_stop_nxt_s = 1'b0;
            if (stop_p_s) begin
               state_nxt_s = ST_IDLE;
            end else if (step_p_s) begin
               state_nxt_s   = ST_STEP;
               ret_brk_nxt_s = 1'b0;
            end else if (start_p_s) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            // Nothing executes on a breakpoint cycle, so an outstanding stop may win there.
            if (bp_hit_s) begin
               state_nxt_s     = stop_req_s ? ST_IDLE : ST_BREAK;
               pend_stop_nxt_s = 1'b0;
            end else if (stop_req_s & done_s) begin
               state_nxt_s     = ST_IDLE;
               pend_stop_nxt_s = 1'b0;
            end else if (stop_p_s) begin
               pend_stop_nxt_s = 1'b1;
            end else begin
               pend_stop_nxt_s = pend_stop_r;
            end
         end
         ST_STEP: begin
            pend_stop_nxt_s = 1'b0;
            if (done_s) begin
               state_nxt_s = ret_brk_r ? ST_BREAK : ST_IDLE;
            end else begin
               state_nxt_s = ST_STEP;
            end
         end
         ST_BREAK: begin
            pend_stop_nxt_s = 1'b0;
            if (stop_p_s) begin
               state_nxt_s = ST_IDLE;
            end else if (step_p_s) begin
               state_nxt_s   = ST_STEP;
               ret_brk_nxt_s = 1'b1;
            end else if (start_p_s) begin
               state_nxt_s   = ST_RUN;
               skip_bp_nxt_s = 1'b1;
            end else begin
               state_nxt_s = ST_BREAK;
            end
         end
         default: begin
            state_nxt_s     = ST_IDLE;
            pend_stop_nxt_s = 1'b0;
         end
      endcase
   end

   // State, button history and instruction-boundary tracking.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r       <= ST_IDLE;
         start_q_r     <= 1'b0;
         stop_q_r      <= 1'b0;
         step_q_r      <= 1'b0;
         instr_start_r <= 1'b1;
         skip_bp_r     <= 1'b0;
         pend_stop_r   <= 1'b0;
         ret_brk_r     <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         start_q_r   <= start_btn;
         stop_q_r    <= stop_btn;
         step_q_r    <= step_btn;
         skip_bp_r   <= skip_bp_nxt_s;
         pend_stop_r <= pend_stop_nxt_s;
         ret_brk_r   <= ret_brk_nxt_s;
         if (run_s) begin
            instr_start_r <= done_s;
         end
      end
   end

`ifdef I281_INSTR_COUNT_EN
   logic [CNT_W-1:0] retired_r;

   // Retired-instruction counter, wraps naturally.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         retired_r <= {CNT_W{1'b0}};
      end else if (done_s) begin
         retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign retired = retired_r;
`else
   assign retired = {CNT_W{1'b0}};
`endif

   assign run      = run_s;
   assign state    = state_r;
   assign halted   = (state_r == ST_IDLE) | (state_r == ST_BREAK);
   assign at_break = (state_r == ST_BREAK);

endmodule
